// File: rtl/egress_pkg.sv
// Shared types and header layout for the egress packet sink.
package egress_pkg;

    // Parser states; S_HDR is the idle/wait-for-sop state.
    typedef enum logic [1:0] {
        S_HDR,
        S_MAC,
        S_TS,
        S_BODY
    } egress_state_t;

    // Word0 field positions.
    localparam int unsigned LEN_MSB     = 26;
    localparam int unsigned LEN_LSB     = 21;
    localparam int unsigned DMAC_HI_MSB = 15;

    // Words in a packet besides the LEN-dependent payload; three are header words.
    localparam int unsigned FIXED_WORDS = 6;
    localparam int unsigned HDR_WORDS   = 3;

    // One record per completed packet, as presented to the CPU.
    typedef struct packed {
        logic        misroute;
        logic [5:0]  len;
        logic [31:0] latency;
    } egress_rec_t;

    // Route lookup shared with the crossbar: the output port is the low two bits of the
    // destination MAC.
    function automatic logic [1:0] mac_to_port(input logic [47:0] dmac);
        return dmac[1:0];
    endfunction

endpackage

// File: rtl/rec_fifo.sv
// Show-ahead synchronous FIFO of egress records. DEPTH must be a power of two, at least 2.
module rec_fifo
    import egress_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  egress_rec_t din,
    output egress_rec_t dout,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    egress_rec_t mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head entry is presented combinationally; zero while empty.
    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/egress_sink.sv
// Per-port egress sink: parses the packet header, checks routing, measures switch latency,
// queues one record per packet and keeps wrap-around statistics.
module egress_sink
    import egress_pkg::*;
#(
    parameter logic [1:0]  PORT_ID   = 2'd0,
    parameter int unsigned REC_DEPTH = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      seg_in,
    input  logic             seg_valid,
    input  logic             seg_sop,
    input  logic [31:0]      time_now,
    input  logic             rec_rd,
    output logic [38:0]      rec_out,
    output logic             rec_empty,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] misroute_cnt,
    output logic [CNT_W-1:0] runt_cnt,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             busy
);

    egress_state_t state_q, state_d;
    logic [5:0]    len_q, len_d;
    logic [47:0]   dmac_q, dmac_d;
    logic [31:0]   ts_q, ts_d;
    logic [6:0]    rem_q, rem_d;       // words still expected, counting the current one
    logic [5:0]    eff_len;
    logic          push, runt_inc, fifo_full;
    egress_rec_t   rec_d, fifo_dout;

    logic [CNT_W-1:0] pkt_cnt_q, misroute_cnt_q, runt_cnt_q, ovf_cnt_q;

    // LEN of zero still carries one payload word.
    assign eff_len = (len_q == 6'd0) ? 6'd1 : len_q;

    // Header parse and word counting; every transition is qualified by seg_valid.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        dmac_d   = dmac_q;
        ts_d     = ts_q;
        rem_d    = rem_q;
        push     = 1'b0;
        runt_inc = 1'b0;

        rec_d.misroute = (mac_to_port(dmac_q) != PORT_ID);
        rec_d.len      = len_q;
        rec_d.latency  = time_now - ts_q;

        if (seg_valid) begin
            if (seg_sop) begin
                // An sop anywhere but S_HDR abandons the packet in flight.
                runt_inc      = (state_q != S_HDR);
                len_d         = seg_in[LEN_MSB:LEN_LSB];
                dmac_d[47:32] = seg_in[DMAC_HI_MSB:0];
                state_d       = S_MAC;
            end else begin
                unique case (state_q)
                    S_HDR: begin
                        // Stray word outside a packet: dropped silently.
                    end
                    S_MAC: begin
                        dmac_d[31:0] = seg_in;
                        state_d      = S_TS;
                    end
                    S_TS: begin
                        ts_d    = seg_in;
                        rem_d   = 7'(FIXED_WORDS - HDR_WORDS) + {1'b0, eff_len};
                        state_d = S_BODY;
                    end
                    S_BODY: begin
                        if (rem_q == 7'd1) begin
                            push    = 1'b1;
                            state_d = S_HDR;
                        end else begin
                            rem_d = rem_q - 7'd1;
                        end
                    end
                    default: state_d = S_HDR;
                endcase
            end
        end
    end

    // Parser state and header registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HDR;
            len_q   <= '0;
            dmac_q  <= '0;
            ts_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            dmac_q  <= dmac_d;
            ts_q    <= ts_d;
            rem_q   <= rem_d;
        end
    end

    // Statistics counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q      <= '0;
            misroute_cnt_q <= '0;
            runt_cnt_q     <= '0;
            ovf_cnt_q      <= '0;
        end else begin
            if (push) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            if (push && rec_d.misroute) misroute_cnt_q <= misroute_cnt_q + CNT_W'(1);
            if (runt_inc) runt_cnt_q <= runt_cnt_q + CNT_W'(1);
            // A same-cycle pop makes room, so only a push into a full, unread FIFO is lost.
            if (push && fifo_full && !rec_rd) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
        end
    end

    rec_fifo #(
        .DEPTH (REC_DEPTH)
    ) u_rec_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (rec_rd),
        .din     (rec_d),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (rec_empty)
    );

    assign rec_out      = fifo_dout;
    assign pkt_cnt      = pkt_cnt_q;
    assign misroute_cnt = misroute_cnt_q;
    assign runt_cnt     = runt_cnt_q;
    assign ovf_cnt      = ovf_cnt_q;
    assign busy         = (state_q != S_HDR);

endmodule

// File: tb/tb_egress_sink.sv
// Bench for egress_sink: packet-level reference model (record queue plus counters) driven by
// directed and randomized packet streams.
module tb_egress_sink;

    localparam logic [1:0] PORT  = 2'd1;
    localparam int         DEPTH = 8;
    localparam int         CW    = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   seg_in;
    logic          seg_valid;
    logic          seg_sop;
    logic [31:0]   time_now;
    logic          rec_rd;
    logic [38:0]   rec_out;
    logic          rec_empty;
    logic [CW-1:0] pkt_cnt, misroute_cnt, runt_cnt, ovf_cnt;
    logic          busy;

    always #5 clk = ~clk;

    egress_sink #(
        .PORT_ID   (PORT),
        .REC_DEPTH (DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .seg_in       (seg_in),
        .seg_valid    (seg_valid),
        .seg_sop      (seg_sop),
        .time_now     (time_now),
        .rec_rd       (rec_rd),
        .rec_out      (rec_out),
        .rec_empty    (rec_empty),
        .pkt_cnt      (pkt_cnt),
        .misroute_cnt (misroute_cnt),
        .runt_cnt     (runt_cnt),
        .ovf_cnt      (ovf_cnt),
        .busy         (busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [38:0] model_q[$];
    int          m_pkt, m_mis, m_runt, m_ovf;
    bit          m_inpkt;
    int          rd_mode;   // 0: never pop, 1: pop every cycle, 2: pop at random

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [38:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 39'd0;
        check("rec_empty", 64'(rec_empty), 64'(model_q.size() == 0));
        check("rec_out", 64'(rec_out), 64'(head));
        check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt & 'hFFFF));
        check("misroute_cnt", 64'(misroute_cnt), 64'(m_mis & 'hFFFF));
        check("runt_cnt", 64'(runt_cnt), 64'(m_runt & 'hFFFF));
        check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf & 'hFFFF));
        check("busy", 64'(busy), 64'(m_inpkt));
    endtask

    task automatic model_clear();
        model_q.delete();
        m_pkt   = 0;
        m_mis   = 0;
        m_runt  = 0;
        m_ovf   = 0;
        m_inpkt = 0;
    endtask

    // One clock: apply inputs, advance the model at the edge, then compare.
    task automatic drive(input logic [31:0] data, input logic valid, input logic sop,
                         input bit done, input logic [38:0] rec);
        bit rd;
        seg_in    = data;
        seg_valid = valid;
        seg_sop   = sop;
        rd        = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 3) == 0);
        rec_rd    = rd;
        @(posedge clk);
        if (rd && model_q.size() > 0) void'(model_q.pop_front());
        if (valid && sop) begin
            if (m_inpkt) m_runt++;
            m_inpkt = 1;
        end
        if (done) begin
            m_inpkt = 0;
            m_pkt++;
            if (rec[38]) m_mis++;
            if (model_q.size() < DEPTH) model_q.push_back(rec);
            else m_ovf++;
        end
        #1;
        seg_valid = 1'b0;
        seg_sop   = 1'b0;
        rec_rd    = 1'b0;
        time_now  = time_now + 1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive($urandom, 1'b0, 1'($urandom), 1'b0, '0);
    endtask

    // Sends one packet of 6 + max(LEN,1) words; stops before word abort_at when it is >= 0.
    task automatic send_packet(input logic [5:0] len, input logic [47:0] dmac,
                               input logic [31:0] ts, input int abort_at,
                               input int gap_at, input int gap_len, input int gap_pct);
        int          total;
        logic [31:0] w;
        logic [38:0] rec;
        total = 6 + ((len == 6'd0) ? 1 : int'(len));
        for (int i = 0; i < total; i++) begin
            if (i == abort_at) return;
            if (i == gap_at) idle(gap_len);
            while ($urandom_range(0, 99) < gap_pct) idle(1);
            w = $urandom;
            if (i == 0) begin
                w[26:21] = len;
                w[15:0]  = dmac[47:32];
            end else if (i == 1) begin
                w = dmac[31:0];
            end else if (i == 2) begin
                w = ts;
            end
            rec = {(dmac % 4) != 48'(PORT), len, time_now - ts};
            drive(w, 1'b1, (i == 0), (i == total - 1), rec);
        end
    endtask

    initial begin
        logic [5:0]  rlen;
        logic [47:0] rmac;
        int          rtot;
        int          rabort;

        reset_n   = 1'b0;
        seg_in    = '0;
        seg_valid = 1'b0;
        seg_sop   = 1'b0;
        time_now  = '0;
        rec_rd    = 1'b0;
        rd_mode   = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_rec_out", 64'(rec_out), 64'd0);
        reset_n = 1'b1;
        idle(1);

        // Basic packet: LEN=3, ts=100, last word at time 140.
        time_now = 32'd132;
        send_packet(6'd3, 48'h0000_1234_5601, 32'd100, -1, -1, 0, 0);
        check("t1_rec", 64'(rec_out), 64'({1'b0, 6'd3, 32'd40}));
        check("t1_pkt", 64'(pkt_cnt), 64'd1);
        check("t1_empty", 64'(rec_empty), 64'd0);
        rd_mode = 1; idle(1); rd_mode = 0;

        // Same packet with a 5-cycle stall mid-body: 9 words + 5 idle -> last at 213.
        time_now = 32'd200;
        send_packet(6'd3, 48'h0000_1234_5601, 32'd100, -1, 5, 5, 0);
        check("t2_rec", 64'(rec_out), 64'({1'b0, 6'd3, 32'd113}));
        rd_mode = 1; idle(1); rd_mode = 0;

        // Early sop at word 4 of a LEN=5 packet, then a complete LEN=1 packet.
        send_packet(6'd5, 48'hABCD_0000_0005, $urandom, 4, -1, 0, 0);
        send_packet(6'd1, 48'h1111_2222_3335, $urandom, -1, -1, 0, 0);
        check("t3_runt", 64'(runt_cnt), 64'd1);
        check("t3_pkt", 64'(pkt_cnt), 64'd3);
        check("t3_len", 64'(rec_out[37:32]), 64'd1);
        rd_mode = 1; idle(2); rd_mode = 0;
        check("t3_single", 64'(rec_empty), 64'd1);

        // Misrouted: MAC maps to port 2.
        send_packet(6'd2, 48'h0102_0304_0506, $urandom, -1, -1, 0, 0);
        check("t4_mis", 64'(misroute_cnt), 64'd1);
        check("t4_bit38", 64'(rec_out[38]), 64'd1);
        rd_mode = 1; idle(1); rd_mode = 0;

        // Nine back-to-back packets into an 8-deep FIFO.
        for (int k = 0; k < 9; k++) send_packet(6'd1, 48'(k * 4 + 1), $urandom, -1, -1, 0, 0);
        check("t5_ovf", 64'(ovf_cnt), 64'd1);
        check("t5_pkt", 64'(pkt_cnt), 64'd13);
        rd_mode = 1; idle(8);
        check("t5_drained", 64'(rec_empty), 64'd1);
        idle(1); rd_mode = 0;

        // Timestamp wrap: ts=0xFFFFFFF0, last word at 0x10.
        time_now = 32'h0000_000A;
        send_packet(6'd1, 48'h0000_0000_0001, 32'hFFFF_FFF0, -1, -1, 0, 0);
        check("t6_latency", 64'(rec_out[31:0]), 64'h20);
        rd_mode = 1; idle(1);

        // Randomized traffic with stalls, aborts, stray words and random pops.
        rd_mode = 2;
        for (int k = 0; k < 40; k++) begin
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                logic [31:0] junk;
                junk = $urandom;
                drive(junk, 1'b1, 1'b0, 1'b0, '0);
            end
            if ($urandom_range(0, 4) == 0) time_now = $urandom;
            rlen   = (k % 8 == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            rmac   = {16'($urandom), 32'($urandom)};
            rtot   = 6 + ((rlen == 6'd0) ? 1 : int'(rlen));
            rabort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, rtot - 1)) : -1;
            send_packet(rlen, rmac, $urandom, rabort, -1, 0, 20);
        end

        // Reset in the middle of a packet body.
        rd_mode = 0;
        send_packet(6'd10, 48'h0000_0000_0001, $urandom, 5, -1, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt", 64'(pkt_cnt), 64'd0);
        check("rst_runt", 64'(runt_cnt), 64'd0);
        check("rst_mis", 64'(misroute_cnt), 64'd0);
        check("rst_ovf", 64'(ovf_cnt), 64'd0);
        check("rst_empty", 64'(rec_empty), 64'd1);
        check("rst_rec_out", 64'(rec_out), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all();
        send_packet(6'd1, 48'h0000_0000_0001, $urandom, -1, -1, 0, 0);
        check("post_rst_pkt", 64'(pkt_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_sink.md
Name: egress_sink

Overview:
- Per-output-port packet sink directly downstream of the crossbar, which carries segments read from the ingress data memory.
- Consumes the 32-bit segment stream and parses the fixed header: word0 carries LEN and the upper 16 bits of the destination MAC, word1 the lower 32 MAC bits, word2 the ingress timestamp.
- Checks that the packet was routed to this port and measures switch latency.
- Pushes one {len, latency, misroute} record per packet into a small FIFO for CPU readout, and keeps wrap-around statistics counters.

Parameters:
- PORT_ID, 0, 2-bit port number this egress serves; compared against mac_to_port(dmac).
- REC_DEPTH, 8, record FIFO depth; must be a power of 2, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- seg_in  in  32  segment from crossbar.
- seg_valid  in  1  seg_in valid this cycle; may drop mid-packet (stall).
- seg_sop  in  1  qualifies seg_in as word0 of a new packet; only meaningful with seg_valid.
- time_now  in  32  free-running global time (same counter that ingress stamps).
- rec_rd  in  1  pop one record.
- rec_out  out  39  {misroute[38], len[37:32], latency[31:0]}, head of FIFO (show-ahead).
- rec_empty  out  1  FIFO empty.
- pkt_cnt  out  CNT_W  packets completed.
- misroute_cnt  out  CNT_W  completed packets whose port != PORT_ID.
- runt_cnt  out  CNT_W  packets aborted by an early seg_sop.
- ovf_cnt  out  CNT_W  records dropped because the FIFO was full.
- busy  out  1  high while in any state other than S_HDR.

Behaviour:
- Reset (async assert, sync deassert): state=S_HDR; all counters 0; FIFO empty; rec_empty=1; rec_out=0; busy=0; internal dmac/ts/len regs 0.
- Packet length: total words = 6 + max(LEN,1), where LEN = word0[26:21]. Word3 onward is payload and is not stored.
- Only cycles with seg_valid=1 are accepted; with seg_valid=0 all state holds.
- States and transitions:
  - S_HDR: accept only when seg_valid & seg_sop. Latch len and dmac[47:32]=seg_in[15:0]; go to S_MAC. A valid word without sop is discarded and no counter changes.
  - S_MAC: latch dmac[31:0]; go to S_TS.
  - S_TS: latch ts=seg_in; load word counter rem = 3 + max(len,1) (the words still to come after word2); go to S_BODY.
  - S_BODY: each valid word decrements rem. When rem==1 on an accepted word (the last word), do the following and go to S_HDR:
    - latency = time_now - ts, modulo 2^32 (wrap is legal);
    - misroute = (mac_to_port(dmac) != PORT_ID);
    - push a record; pkt_cnt+1; misroute_cnt+1 if misroute.
- Early sop: seg_valid & seg_sop in S_MAC, S_TS or S_BODY aborts the current packet. runt_cnt+1, no record is pushed, and the word is treated as word0 of the new packet (next state S_MAC).
- FIFO:
  - Push when full: record dropped, ovf_cnt+1, pkt_cnt still +1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: ignored.
  - rec_out is valid combinationally from the head entry, and updates the cycle after a pop.
- Counters wrap at 2^CNT_W with no saturation.
- Record latency: the record is visible on rec_out one cycle after the last word's clock edge.
- Asserting reset_n mid-packet discards the partial packet and clears the FIFO and counters immediately.

Decomposition:
- egress_pkg holds:
  - state enum (S_HDR, S_MAC, S_TS, S_BODY);
  - header field constants: LEN_MSB=26, LEN_LSB=21, DMAC_HI_MSB=15;
  - FIXED_WORDS=6;
  - packed record struct egress_rec_t {misroute, len[5:0], latency[31:0]}.
- Sub-module rec_fifo: parameterised show-ahead sync FIFO of egress_rec_t, with async active-low reset and full/empty flags.
- Reuse the existing mac_to_port combinational block for the route check.

Test Plan:
- PORT_ID=1, single packet, LEN=3, dmac maps to port 1, word2 ts=100, last word accepted at time_now=140 -> rec_out={0,3,40}, pkt_cnt=1, rec_empty=0 one cycle after the last word.
- Same packet with seg_valid deasserted 5 cycles mid-body, ts=100 -> latency = completion time - 100, only 9 words counted, state held during the gap.
- New seg_sop at word 4 of a LEN=5 packet, followed by a full LEN=1 packet -> runt_cnt=1, pkt_cnt=1, exactly one record with len=1.
- dmac maps to port 2 while PORT_ID=1 -> misroute_cnt=1, record bit38=1.
- 9 back-to-back LEN=1 packets with no rec_rd, REC_DEPTH=8 -> ovf_cnt=1, pkt_cnt=9. Then 8 pops return in order and rec_empty=1. A pop while empty changes nothing.
- ts=0xFFFFFFF0, completion at time_now=0x00000010 -> latency=0x20. Asserting reset_n mid-body -> busy=0, all counters 0, rec_empty=1.
